// File: rtl/sar_adc_ctrl.sv
// -----------------------------------------------------------------------------
// sar_adc_ctrl
//   Successive-approximation ADC controller that sits behind a sample-and-hold.
//   It generates the sampler clock (0 = track, 1 = hold), runs an N_BIT binary
//   search against an ideal internal DAC, MSB first, one bit per clock, and
//   presents the final code together with a one-cycle valid strobe.
//
//   The held analog level arrives as a signed fixed-point voltage in
//   microvolts, so the DAC references and comparator offset are also given in
//   microvolts. The comparison is made exactly in integers by scaling both
//   sides by 2^N_BIT, which avoids carrying a fractional LSB.
//
// Parameters
//   N_BIT       resolution in bits (2..16)
//   N_TRACK     clk cycles spent tracking before hold (>= 1)
//   VREF_LO_UV  DAC bottom reference [uV]
//   VREF_HI_UV  DAC top reference [uV]
//   VOS_UV      comparator input-referred offset [uV], added to the DAC level
//
// Ports
//   clk    conversion clock, all state changes on the rising edge
//   rst    synchronous active-high reset
//   vin    held voltage from the sample-and-hold, signed, [uV]
//   en     conversion enable, sampled on the rising edge
//   sclk   sample clock to the sample-and-hold (0 = track, 1 = hold)
//   dout   last completed conversion code, unsigned
//   valid  one-cycle strobe, dout is new
//   busy   high while tracking or converting
// -----------------------------------------------------------------------------
module sar_adc_ctrl #(
    parameter int N_BIT      = 8,
    parameter int N_TRACK    = 2,
    parameter int VREF_LO_UV = 0,
    parameter int VREF_HI_UV = 1000000,
    parameter int VOS_UV     = 0
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [31:0]      vin,
    input  logic                    en,
    output logic                    sclk,
    output logic [N_BIT-1:0]        dout,
    output logic                    valid,
    output logic                    busy
);

    localparam int CW = (N_TRACK > 1) ? $clog2(N_TRACK) : 1;
    localparam int IW = $clog2(N_BIT);
    localparam logic signed [63:0] SPAN = 64'(VREF_HI_UV) - 64'(VREF_LO_UV);

    typedef enum logic [1:0] {IDLE, TRACK, CONVERT, DONE} state_t;

    state_t            state, state_nx;
    logic [CW-1:0]     tcnt;
    logic [N_BIT-1:0]  trial;
    logic [IW-1:0]     idx;

    // Comparator: v >= LO + trial*SPAN/2^N + VOS, both sides scaled by 2^N.
    logic signed [63:0] vin_ext;
    logic signed [63:0] vdiff_sc;
    logic signed [63:0] dac_sc;
    logic               keep;
    logic [N_BIT-1:0]   cur_bit;
    logic [N_BIT-1:0]   nxt_bit;
    logic [N_BIT-1:0]   trial_dec;

    assign vin_ext  = {{32{vin[31]}}, vin};
    assign vdiff_sc = (vin_ext - 64'(VREF_LO_UV) - 64'(VOS_UV)) <<< N_BIT;
    assign dac_sc   = $signed({{(64-N_BIT){1'b0}}, trial}) * SPAN;
    assign keep     = (vdiff_sc >= dac_sc);   // equality resolves to 1

    // Only bits of the trial word are ever set, so the code cannot wrap.
    // On the LSB decision nxt_bit shifts out to zero.
    assign cur_bit   = N_BIT'(1) << idx;
    assign nxt_bit   = cur_bit >> 1;
    assign trial_dec = (keep ? trial : (trial & ~cur_bit)) | nxt_bit;

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Next-state logic; en is ignored while tracking or converting
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (en) state_nx = TRACK;
            TRACK:   if (tcnt == CW'(N_TRACK-1)) state_nx = CONVERT;
            CONVERT: if (idx == '0) state_nx = DONE;
            DONE:    state_nx = en ? TRACK : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath registers: track counter, trial word, bit index, result
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt  <= '0;
            trial <= '0;
            idx   <= IW'(N_BIT-1);
            dout  <= '0;
        end else begin
            case (state)
                IDLE, DONE: tcnt <= '0;
                TRACK: begin
                    tcnt <= tcnt + CW'(1);
                    if (tcnt == CW'(N_TRACK-1)) begin
                        trial <= N_BIT'(1) << (N_BIT-1);
                        idx   <= IW'(N_BIT-1);
                    end
                end
                CONVERT: begin
                    trial <= trial_dec;
                    if (idx == '0) dout <= trial_dec;
                    else           idx  <= idx - IW'(1);
                end
                default: ;
            endcase
        end
    end

    // Outputs are pure functions of the state
    always_comb begin
        sclk  = 1'b0;
        busy  = 1'b0;
        valid = 1'b0;
        case (state)
            TRACK:   busy  = 1'b1;
            CONVERT: begin
                sclk = 1'b1;
                busy = 1'b1;
            end
            DONE:    valid = 1'b1;
            default: ;
        endcase
    end

endmodule
